mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width of all address ports.
REQ-002 SHALL have parameter MAX_BEATS, default 16: maximum debug burst length; a power of two, at most 16.
REQ-003 SHALL have port CLK, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port nReset, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have CPU-side ports: cpu_req in 1; cpu_we in 1; cpu_addr in ADDR_W; cpu_wdata in 32; cpu_gnt out 1; cpu_rvalid out 1; cpu_rdata out 32.
REQ-006 SHALL have debug/loader-side ports: dbg_req in 1; dbg_we in 1; dbg_addr in ADDR_W; dbg_wdata in 32; dbg_len in 4 (beats minus 1); dbg_gnt out 1; dbg_rvalid out 1; dbg_rdata out 32.
REQ-007 SHALL have memory-side ports: mem_en out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out 32; mem_rdata in 32 (valid one cycle after a read access).
REQ-008 SHALL have port busy, output, 1: high while a debug burst is in progress.

Function
REQ-009 SHALL implement a state machine with three states: IDLE, CPU_ACC and DBG_BURST.
REQ-010 Grant timing SHALL be combinational in the request cycle: a granted requester's addr, we and wdata drive mem_* in that same cycle, with mem_en=1.
REQ-011 Contention (both requests in IDLE or CPU_ACC) SHALL be resolved round-robin on a last-winner bit: the winner is the requester not recorded; the bit resets to DBG, so the CPU wins the first contention.
REQ-012 CPU accesses SHALL be single-beat; CPU_ACC SHALL be held for one cycle and then return to IDLE unless the CPU wins again.
REQ-013 A debug grant SHALL sample min(dbg_len+1, MAX_BEATS) into a beat counter and dbg_addr into an address register, then enter DBG_BURST while beats remain.
REQ-014 In DBG_BURST, dbg_gnt=1 and cpu_gnt=0; beat n SHALL use mem_addr = sampled addr + 4n, modulo 2^ADDR_W, with dbg_wdata and dbg_we taken per beat.
REQ-015 Burst termination: the burst SHALL end after the final beat; if dbg_req falls mid-burst, the burst SHALL abort with no access that cycle and return to IDLE.
REQ-016 Read return: rvalid SHALL assert exactly one cycle after a granted read, to the owner registered at grant; rdata = mem_rdata when rvalid is high, else 0. Writes SHALL produce no rvalid.
REQ-017 cpu_gnt and dbg_gnt SHALL never both be 1; with no request, mem_en=0 and mem_we=0.
REQ-018 busy SHALL be 1 in DBG_BURST, else 0.

Reset
REQ-019 On nReset low, the following SHALL clear immediately: state=IDLE, beat counter=0, address register=0, last-winner=DBG, both rvalid=0, all gnt/mem_* outputs=0.
REQ-020 Reset mid-burst SHALL abandon the burst, with no pending rvalid after release.
REQ-021 Release of reset SHALL be followed by normal arbitration on the first rising edge.

Configuration
REQ-022 Macro ARB_STATS_EN SHALL control statistics. Defined: adds output contention_cnt, 16 bits, a saturating count of cycles in which cpu_req=1 and cpu_gnt=0; it clears on reset and holds at 0xFFFF. Undefined: the port and counter are absent, with arbitration behaviour identical.

Structure
REQ-023 A shared package SHALL hold the state enum (IDLE, CPU_ACC, DBG_BURST), the owner enum (OWN_CPU, OWN_DBG) and the word-stride constant 4.
REQ-024 Sub-module: one, burst_counter (load, decrement, last-beat flag, address increment).

Verification
REQ-025 Scenario 1: cpu_req read at 0x100, mem_rdata=0xDEADBEEF -> cpu_gnt same cycle; cpu_rvalid next cycle with cpu_rdata 0xDEADBEEF.
REQ-026 Scenario 2: both request in the first cycle after reset -> CPU wins; persistent contention -> grants alternate CPU, DBG(burst), CPU.
REQ-027 Scenario 3: dbg write burst, dbg_len=3, addr 0x200 -> mem_addr 0x200, 0x204, 0x208, 0x20C on 4 consecutive cycles; cpu_gnt=0 throughout; busy=1 for 4 cycles.
REQ-028 Scenario 4: burst at addr 0xFFFFFFFC, dbg_len=1 -> second beat at 0x00000000.
REQ-029 Scenario 5: dbg_req dropped after beat 2 of 8 -> return to IDLE next cycle; pending CPU request granted.
REQ-030 Scenario 6: nReset asserted mid read burst -> all outputs 0 asynchronously; no rvalid after release. With ARB_STATS_EN, 70000 contention cycles -> contention_cnt=0xFFFF.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types and constants for the CPU / debug-loader memory port arbiter:
//   arbState_e  - arbiter FSM states (IDLE, CPU_ACC, DBG_BURST)
//   owner_e     - requester identity used for round-robin and read return
//   WORD_STRIDE - byte distance between consecutive debug burst beats
//   burstBeats  - clamps a requested burst length to the configured maximum
// ---------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU_ACC   = 2'd1,
    DBG_BURST = 2'd2
  } arbState_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_e;

  localparam int unsigned WORD_STRIDE = 4;

  // Number of beats to perform: min(len + 1, maxBeats).
  function automatic logic [4:0] burstBeats(input logic [3:0] len, input int unsigned maxBeats);
    logic [4:0] reqBeats;
    reqBeats = {1'b0, len} + 5'd1;
    if (reqBeats > 5'(maxBeats)) begin
      burstBeats = 5'(maxBeats);
    end else begin
      burstBeats = reqBeats;
    end
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the arbiter's bus signals.
//   cpu_*  : single-beat CPU port (req/we/addr/wdata in, gnt/rvalid/rdata out)
//   dbg_*  : debug/loader burst port (adds dbg_len = beats - 1)
//   mem_*  : shared memory port (mem_rdata valid one cycle after a read)
//   busy   : debug burst in progress
// Modports:
//   slave  - the arbiter
//   master - requesters and memory model (testbench side)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [31:0]       cpu_rdata;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [31:0]       dbg_wdata;
  logic [3:0]        dbg_len;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [31:0]       dbg_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_len,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_len,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/mem_port_arbiter_burst_counter.sv
// ---------------------------------------------------------------------------
// burst_counter
// Tracks the remainder of a debug burst.
//   CLK, nReset : clock, asynchronous active-low reset
//   load        : grant cycle; beat 0 is issued at startAddr this cycle
//   step        : a burst beat is issued this cycle at beatAddr
//   clear       : burst abandoned
//   len         : requested beats minus 1
//   startAddr   : first beat address
//   beatAddr    : address of the next beat (wraps modulo 2^ADDR_W)
//   lastBeat    : the next beat is the final one
//   multiBeat   : the burst being loaded has more than one beat
// The clamped total is sampled at load, and beat 0 (issued in the grant
// cycle) is consumed immediately, so countR holds beats still to issue.
// ---------------------------------------------------------------------------
module burst_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic              CLK,
  input  logic              nReset,
  input  logic              load,
  input  logic              step,
  input  logic              clear,
  input  logic [3:0]        len,
  input  logic [ADDR_W-1:0] startAddr,
  output logic [ADDR_W-1:0] beatAddr,
  output logic              lastBeat,
  output logic              multiBeat
);

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_STRIDE);

  logic [4:0]        countR;
  logic [ADDR_W-1:0] addrR;
  logic [4:0]        totalS;

  assign totalS    = burstBeats(len, MAX_BEATS);
  assign multiBeat = (totalS > 5'd1);
  // A count of 0 inside a burst cannot occur; treating it as last keeps the
  // FSM from getting stuck if it ever did.
  assign lastBeat  = (countR <= 5'd1);
  assign beatAddr  = addrR;

  // Remaining-beat counter and next-beat address register.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      countR <= 5'd0;
      addrR  <= '0;
    end else if (clear) begin
      countR <= 5'd0;
      addrR  <= '0;
    end else if (load) begin
      countR <= totalS - 5'd1;
      addrR  <= startAddr + STRIDE;
    end else if (step) begin
      countR <= countR - 5'd1;
      addrR  <= addrR + STRIDE;
    end else begin
      countR <= countR;
      addrR  <= addrR;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Arbitrates a single memory port between a CPU (single-beat accesses) and a
// debug/loader master (incrementing word bursts of up to MAX_BEATS beats).
// Grants are combinational: the winner's addr/we/wdata reach mem_* in the
// request cycle. Contention is round-robin on a last-winner bit (reset: DBG,
// so the CPU wins first). Read data returns one cycle later to the owner
// recorded at grant.
// Ports:
//   CLK     : clock, rising edge
//   nReset  : asynchronous active-low reset; also forces all outputs to 0
//   bus     : mem_port_arbiter_if.slave (cpu_*, dbg_*, mem_*, busy)
//   contention_cnt (only with ARB_STATS_EN): saturating 16-bit count of
//             cycles with cpu_req=1 and cpu_gnt=0
// Build option: define ARB_STATS_EN to add the contention statistics.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic CLK,
  input  logic nReset,
  mem_port_arbiter_if.slave bus
`ifdef ARB_STATS_EN
  ,
  output logic [15:0] contention_cnt
`endif
);

  arbState_e         stateR;
  arbState_e         nextStateS;
  owner_e            lastWinnerR;
  owner_e            lastWinnerS;
  logic              rvPendR;
  owner_e            rvOwnerR;

  logic              cpuGntS;
  logic              dbgGntS;
  logic              memEnS;
  logic              memWeS;
  logic [ADDR_W-1:0] memAddrS;
  logic [31:0]       memWdataS;
  logic              busyS;

  logic              bcLoadS;
  logic              bcStepS;
  logic              bcClearS;
  logic [ADDR_W-1:0] bcAddr;
  logic              bcLast;
  logic              bcMulti;

  burst_counter #(
    .ADDR_W    (ADDR_W),
    .MAX_BEATS (MAX_BEATS)
  ) uBurstCounter (
    .CLK       (CLK),
    .nReset    (nReset),
    .load      (bcLoadS),
    .step      (bcStepS),
    .clear     (bcClearS),
    .len       (bus.dbg_len),
    .startAddr (bus.dbg_addr),
    .beatAddr  (bcAddr),
    .lastBeat  (bcLast),
    .multiBeat (bcMulti)
  );

  // Next-state, grant and memory-port steering.
  always_comb begin
    nextStateS  = stateR;
    lastWinnerS = lastWinnerR;
    cpuGntS     = 1'b0;
    dbgGntS     = 1'b0;
    memEnS      = 1'b0;
    memWeS      = 1'b0;
    memAddrS    = '0;
    memWdataS   = 32'd0;
    busyS       = 1'b0;
    bcLoadS     = 1'b0;
    bcStepS     = 1'b0;
    bcClearS    = 1'b0;
    case (stateR)
      IDLE, CPU_ACC: begin
        // CPU wins if alone, or on contention when DBG won last time.
        if (bus.cpu_req && (!bus.dbg_req || (lastWinnerR == OWN_DBG))) begin
          cpuGntS     = 1'b1;
          memEnS      = 1'b1;
          memWeS      = bus.cpu_we;
          memAddrS    = bus.cpu_addr;
          memWdataS   = bus.cpu_wdata;
          lastWinnerS = OWN_CPU;
          nextStateS  = CPU_ACC;
        end else if (bus.dbg_req) begin
          dbgGntS     = 1'b1;
          memEnS      = 1'b1;
          memWeS      = bus.dbg_we;
          memAddrS    = bus.dbg_addr;
          memWdataS   = bus.dbg_wdata;
          lastWinnerS = OWN_DBG;
          bcLoadS     = 1'b1;
          // The grant cycle is beat 0 of a multi-beat burst, so busy
          // already covers it; single-beat debug accesses never go busy.
          if (bcMulti) begin
            nextStateS = DBG_BURST;
            busyS      = 1'b1;
          end else begin
            nextStateS = IDLE;
          end
        end else begin
          nextStateS = IDLE;
        end
      end
      DBG_BURST: begin
        busyS = 1'b1;
        if (bus.dbg_req) begin
          dbgGntS   = 1'b1;
          memEnS    = 1'b1;
          memWeS    = bus.dbg_we;
          memAddrS  = bcAddr;
          memWdataS = bus.dbg_wdata;
          bcStepS   = 1'b1;
          if (bcLast) begin
            nextStateS = IDLE;
          end else begin
            nextStateS = DBG_BURST;
          end
        end else begin
          // Requester withdrew: abort with no access this cycle.
          bcClearS   = 1'b1;
          nextStateS = IDLE;
        end
      end
      default: begin
        nextStateS = IDLE;
      end
    endcase
  end

  // FSM state, round-robin bit and read-return tracking.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      stateR      <= IDLE;
      lastWinnerR <= OWN_DBG;
      rvPendR     <= 1'b0;
      rvOwnerR    <= OWN_CPU;
    end else begin
      stateR      <= nextStateS;
      lastWinnerR <= lastWinnerS;
      rvPendR     <= memEnS && !memWeS;
      rvOwnerR    <= dbgGntS ? OWN_DBG : OWN_CPU;
    end
  end

  // Combinational grant paths are forced low while reset is asserted.
  assign bus.cpu_gnt   = nReset & cpuGntS;
  assign bus.dbg_gnt   = nReset & dbgGntS;
  assign bus.mem_en    = nReset & memEnS;
  assign bus.mem_we    = nReset & memWeS;
  assign bus.mem_addr  = nReset ? memAddrS : '0;
  assign bus.mem_wdata = nReset ? memWdataS : 32'd0;
  assign bus.busy      = nReset & busyS;

  assign bus.cpu_rvalid = rvPendR && (rvOwnerR == OWN_CPU);
  assign bus.dbg_rvalid = rvPendR && (rvOwnerR == OWN_DBG);
  assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : 32'd0;
  assign bus.dbg_rdata  = bus.dbg_rvalid ? bus.mem_rdata : 32'd0;

`ifdef ARB_STATS_EN
  logic [15:0] contentionCntR;

  // Saturating count of cycles in which the CPU requests but is not granted.
  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      contentionCntR <= 16'd0;
    end else if (bus.cpu_req && !cpuGntS && (contentionCntR != 16'hFFFF)) begin
      contentionCntR <= contentionCntR + 16'd1;
    end else begin
      contentionCntR <= contentionCntR;
    end
  end

  assign contention_cnt = contentionCntR;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed, table-driven bench for mem_port_arbiter. Inputs change 1 time
// unit after the rising edge; outputs are compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic nReset;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32)) bus ();

`ifdef ARB_STATS_EN
  logic [15:0] contentionCnt;
`endif

  mem_port_arbiter #(
    .ADDR_W    (32),
    .MAX_BEATS (16)
  ) dut (
    .CLK    (clk),
    .nReset (nReset),
    .bus    (bus)
`ifdef ARB_STATS_EN
    ,
    .contention_cnt (contentionCnt)
`endif
  );

  typedef struct {
    logic        cr;   logic cw;  logic [31:0] ca; logic [31:0] cd;
    logic        dr;   logic dw;  logic [31:0] da; logic [31:0] dd;
    logic [3:0]  dl;   logic [31:0] mr;
    logic        eCg;  logic eDg; logic eEn; logic eWe;
    logic [31:0] eAddr; logic [31:0] eWd;
    logic        eCrv; logic [31:0] eCrd;
    logic        eDrv; logic [31:0] eDrd;
    logic        eBusy;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [0:NVEC-1];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic setIn(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                       input logic [3:0] dl, input logic [31:0] mr);
    bus.cpu_req   = cr; bus.cpu_we  = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dbg_req   = dr; bus.dbg_we  = dw; bus.dbg_addr = da; bus.dbg_wdata = dd;
    bus.dbg_len   = dl; bus.mem_rdata = mr;
  endtask

  task automatic chkOut(input string tag, input logic cg, input logic dg, input logic en, input logic we,
                        input logic [31:0] addr, input logic [31:0] wd, input logic crv, input logic [31:0] crd,
                        input logic drv, input logic [31:0] drd, input logic bsy);
    chk({tag, ".cpu_gnt"},    32'(bus.cpu_gnt),    32'(cg));
    chk({tag, ".dbg_gnt"},    32'(bus.dbg_gnt),    32'(dg));
    chk({tag, ".mem_en"},     32'(bus.mem_en),     32'(en));
    chk({tag, ".mem_we"},     32'(bus.mem_we),     32'(we));
    chk({tag, ".mem_addr"},   bus.mem_addr,        addr);
    chk({tag, ".mem_wdata"},  bus.mem_wdata,       wd);
    chk({tag, ".cpu_rvalid"}, 32'(bus.cpu_rvalid), 32'(crv));
    chk({tag, ".cpu_rdata"},  bus.cpu_rdata,       crd);
    chk({tag, ".dbg_rvalid"}, 32'(bus.dbg_rvalid), 32'(drv));
    chk({tag, ".dbg_rdata"},  bus.dbg_rdata,       drd);
    chk({tag, ".busy"},       32'(bus.busy),       32'(bsy));
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // cr cw ca cd | dr dw da dd dl mr || cg dg en we addr wd crv crd drv drd busy
    // Contention from reset: CPU, DBG 2-beat burst, CPU again.
    vecs[0]  = '{1'b1,1'b0,32'h300,32'hC0C0_0001, 1'b1,1'b0,32'h400,32'hD0D0_0001, 4'd1,32'h0,
                 1'b1,1'b0,1'b1,1'b0,32'h300,32'hC0C0_0001, 1'b0,32'h0, 1'b0,32'h0, 1'b0};
    vecs[1]  = '{1'b1,1'b0,32'h300,32'hC0C0_0001, 1'b1,1'b0,32'h400,32'hD0D0_0001, 4'd1,32'hAAAA_0001,
                 1'b0,1'b1,1'b1,1'b0,32'h400,32'hD0D0_0001, 1'b1,32'hAAAA_0001, 1'b0,32'h0, 1'b1};
    vecs[2]  = '{1'b1,1'b0,32'h300,32'hC0C0_0001, 1'b1,1'b0,32'h400,32'hD0D0_0001, 4'd1,32'hBBBB_0002,
                 1'b0,1'b1,1'b1,1'b0,32'h404,32'hD0D0_0001, 1'b0,32'h0, 1'b1,32'hBBBB_0002, 1'b1};
    vecs[3]  = '{1'b1,1'b0,32'h300,32'hC0C0_0001, 1'b1,1'b0,32'h400,32'hD0D0_0001, 4'd1,32'hBBBB_0003,
                 1'b1,1'b0,1'b1,1'b0,32'h300,32'hC0C0_0001, 1'b0,32'h0, 1'b1,32'hBBBB_0003, 1'b0};
    vecs[4]  = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 4'd0,32'hCCCC_0004,
                 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b1,32'hCCCC_0004, 1'b0,32'h0, 1'b0};
    // CPU read at 0x100, data returned next cycle; rdata is 0 without rvalid.
    vecs[5]  = '{1'b1,1'b0,32'h100,32'h0, 1'b0,1'b0,32'h0,32'h0, 4'd0,32'h0,
                 1'b1,1'b0,1'b1,1'b0,32'h100,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b0};
    vecs[6]  = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 4'd0,32'hDEAD_BEEF,
                 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b1,32'hDEAD_BEEF, 1'b0,32'h0, 1'b0};
    vecs[7]  = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 4'd0,32'h1234_5678,
                 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b0};
    // 4-beat write burst at 0x200 while the CPU is also requesting.
    vecs[8]  = '{1'b1,1'b0,32'h500,32'h0, 1'b1,1'b1,32'h200,32'hA000, 4'd3,32'h0,
                 1'b0,1'b1,1'b1,1'b1,32'h200,32'hA000, 1'b0,32'h0, 1'b0,32'h0, 1'b1};
    vecs[9]  = '{1'b1,1'b0,32'h500,32'h0, 1'b1,1'b1,32'h200,32'hA001, 4'd3,32'h0,
                 1'b0,1'b1,1'b1,1'b1,32'h204,32'hA001, 1'b0,32'h0, 1'b0,32'h0, 1'b1};
    vecs[10] = '{1'b1,1'b0,32'h500,32'h0, 1'b1,1'b1,32'h200,32'hA002, 4'd3,32'h0,
                 1'b0,1'b1,1'b1,1'b1,32'h208,32'hA002, 1'b0,32'h0, 1'b0,32'h0, 1'b1};
    vecs[11] = '{1'b1,1'b0,32'h500,32'h0, 1'b1,1'b1,32'h200,32'hA003, 4'd3,32'h0,
                 1'b0,1'b1,1'b1,1'b1,32'h20C,32'hA003, 1'b0,32'h0, 1'b0,32'h0, 1'b1};
    vecs[12] = '{1'b1,1'b0,32'h500,32'h0, 1'b0,1'b0,32'h0,32'h0, 4'd0,32'h0,
                 1'b1,1'b0,1'b1,1'b0,32'h500,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b0};
    vecs[13] = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 4'd0,32'h55AA_55AA,
                 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b1,32'h55AA_55AA, 1'b0,32'h0, 1'b0};
    // 2-beat read burst wrapping past the top of the address space.
    vecs[14] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'hFFFF_FFFC,32'h0, 4'd1,32'h0,
                 1'b0,1'b1,1'b1,1'b0,32'hFFFF_FFFC,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b1};
    vecs[15] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b0,32'hFFFF_FFFC,32'h0, 4'd1,32'h4444_0001,
                 1'b0,1'b1,1'b1,1'b0,32'h0,32'h0, 1'b0,32'h0, 1'b1,32'h4444_0001, 1'b1};
    vecs[16] = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 4'd0,32'h4444_0002,
                 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0, 1'b1,32'h4444_0002, 1'b0};
    // Single-beat debug writes: no burst state, busy stays low.
    vecs[17] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h600,32'h6006, 4'd0,32'h0,
                 1'b0,1'b1,1'b1,1'b1,32'h600,32'h6006, 1'b0,32'h0, 1'b0,32'h0, 1'b0};
    vecs[18] = '{1'b0,1'b0,32'h0,32'h0, 1'b1,1'b1,32'h604,32'h6007, 4'd0,32'h0,
                 1'b0,1'b1,1'b1,1'b1,32'h604,32'h6007, 1'b0,32'h0, 1'b0,32'h0, 1'b0};
    vecs[19] = '{1'b0,1'b0,32'h0,32'h0, 1'b0,1'b0,32'h0,32'h0, 4'd0,32'h7777_7777,
                 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b0};

    // Reset with both requests active: every output must stay low.
    nReset = 1'b0;
    setIn(1'b1, 1'b1, 32'h10, 32'h11, 1'b1, 1'b1, 32'h20, 32'h22, 4'd3, 32'h9999_9999);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chkOut("reset", 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b0);
`ifdef ARB_STATS_EN
    chk("reset.contention_cnt", 32'(contentionCnt), 32'd0);
`endif
    setIn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 32'h0);
    nReset = 1'b1;
    nextCycle();

    for (int i = 0; i < NVEC; i++) begin
      setIn(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd, vecs[i].dr, vecs[i].dw,
            vecs[i].da, vecs[i].dd, vecs[i].dl, vecs[i].mr);
      @(negedge clk);
      chkOut($sformatf("v%0d", i), vecs[i].eCg, vecs[i].eDg, vecs[i].eEn, vecs[i].eWe,
             vecs[i].eAddr, vecs[i].eWd, vecs[i].eCrv, vecs[i].eCrd, vecs[i].eDrv,
             vecs[i].eDrd, vecs[i].eBusy);
      nextCycle();
    end

    // Debug request withdrawn after 2 of 8 beats; the waiting CPU follows.
    setIn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h800, 32'h0, 4'd7, 32'h0);
    @(negedge clk);
    chkOut("abort.b0", 1'b0,1'b1,1'b1,1'b0,32'h800,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b1);
    nextCycle();
    setIn(1'b1, 1'b1, 32'h900, 32'h99, 1'b1, 1'b0, 32'h800, 32'h0, 4'd7, 32'h0);
    @(negedge clk);
    chkOut("abort.b1", 1'b0,1'b1,1'b1,1'b0,32'h804,32'h0, 1'b0,32'h0, 1'b1,32'h0, 1'b1);
    nextCycle();
    setIn(1'b1, 1'b1, 32'h900, 32'h99, 1'b0, 1'b0, 32'h800, 32'h0, 4'd7, 32'h5151_5151);
    @(negedge clk);
    chkOut("abort.drop", 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0, 1'b1,32'h5151_5151, 1'b1);
    nextCycle();
    @(negedge clk);
    chkOut("abort.cpu", 1'b1,1'b0,1'b1,1'b1,32'h900,32'h99, 1'b0,32'h0, 1'b0,32'h0, 1'b0);
    nextCycle();
    setIn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 32'h0);
    nextCycle();

    // Reset asserted in the middle of a read burst.
    setIn(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'hA00, 32'h0, 4'd7, 32'h0);
    @(negedge clk);
    chkOut("rstmid.b0", 1'b0,1'b1,1'b1,1'b0,32'hA00,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b1);
    nextCycle();
    @(negedge clk);
    chkOut("rstmid.b1", 1'b0,1'b1,1'b1,1'b0,32'hA04,32'h0, 1'b0,32'h0, 1'b1,32'h0, 1'b1);
    #2;
    bus.cpu_req   = 1'b1;
    bus.mem_rdata = 32'hFFFF_0000;
    nReset        = 1'b0;
    #1;
    chkOut("rstmid.async", 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b0);
    nextCycle();
    setIn(1'b1, 1'b0, 32'hB00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 32'h0);
    nReset = 1'b1;
    @(negedge clk);
    chkOut("rstmid.rel", 1'b1,1'b0,1'b1,1'b0,32'hB00,32'h0, 1'b0,32'h0, 1'b0,32'h0, 1'b0);
    nextCycle();
    setIn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 32'h0B00_B00B);
    @(negedge clk);
    chkOut("rstmid.rd", 1'b0,1'b0,1'b0,1'b0,32'h0,32'h0, 1'b1,32'h0B00_B00B, 1'b0,32'h0, 1'b0);
    nextCycle();

`ifdef ARB_STATS_EN
    // Long contention run: CPU loses 16 of every 17 cycles, so the counter
    // must saturate rather than wrap.
    nReset = 1'b0;
    #1;
    chk("stats.reset", 32'(contentionCnt), 32'd0);
    nReset = 1'b1;
    setIn(1'b1, 1'b0, 32'hC00, 32'h0, 1'b1, 1'b0, 32'hD00, 32'h0, 4'd15, 32'h0);
    repeat (70000) @(posedge clk);
    #1;
    chk("stats.saturate", 32'(contentionCnt), 32'h0000_FFFF);
    setIn(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0, 32'h0);
    nextCycle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
